// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per result producer, round-robin grant,
// registered broadcast of at most one result per cycle.
module cdb_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic                         flush,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]     req_tag,
  input  logic [NUM_REQ*DATA_W-1:0]    req_val,
  input  logic [NUM_REQ*DATA_W-1:0]    req_addr,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         cdb_active,
  output logic [TAG_W-1:0]             cdb_tag,
  output logic [DATA_W-1:0]            cdb_val,
  output logic [DATA_W-1:0]            cdb_addr,
  output logic [$clog2(NUM_REQ+1)-1:0] pending
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(NUM_REQ + 1);

  logic [NUM_REQ-1:0]             r_slot_valid, w_slot_valid_d;
  logic [NUM_REQ-1:0][TAG_W-1:0]  r_slot_tag, w_slot_tag_d;
  logic [NUM_REQ-1:0][DATA_W-1:0] r_slot_val, w_slot_val_d;
  logic [NUM_REQ-1:0][DATA_W-1:0] r_slot_addr, w_slot_addr_d;
  logic [PTR_W-1:0]               r_ptr, w_ptr_d;

  logic                           r_cdb_active, w_cdb_active_d;
  logic [TAG_W-1:0]               r_cdb_tag, w_cdb_tag_d;
  logic [DATA_W-1:0]              r_cdb_val, w_cdb_val_d;
  logic [DATA_W-1:0]              r_cdb_addr, w_cdb_addr_d;

  logic [NUM_REQ-1:0]             w_grant;
  logic [PTR_W-1:0]               w_grant_idx;
  logic                           w_grant_any;
  logic [CNT_W-1:0]               w_pending;

  // Round-robin scan starting at r_ptr; first valid slot wins.
  always_comb begin
    int unsigned idx;
    logic [PTR_W-1:0] sel;
    idx         = 0;
    sel         = '0;
    w_grant     = '0;
    w_grant_idx = '0;
    w_grant_any = 1'b0;
    if (rdy_in && !flush) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        idx = 32'(r_ptr) + k;
        if (idx >= NUM_REQ) begin
          idx = idx - NUM_REQ;
        end
        sel = PTR_W'(idx);
        if (!w_grant_any && r_slot_valid[sel]) begin
          w_grant[sel] = 1'b1;
          w_grant_idx  = sel;
          w_grant_any  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = rdy_in & ~flush & (~r_slot_valid[i] | w_grant[i]);
    end
  end

  always_comb begin
    w_slot_valid_d = r_slot_valid;
    w_slot_tag_d   = r_slot_tag;
    w_slot_val_d   = r_slot_val;
    w_slot_addr_d  = r_slot_addr;
    w_ptr_d        = r_ptr;
    w_cdb_active_d = r_cdb_active;
    w_cdb_tag_d    = r_cdb_tag;
    w_cdb_val_d    = r_cdb_val;
    w_cdb_addr_d   = r_cdb_addr;
    if (rdy_in) begin
      if (flush) begin
        w_slot_valid_d = '0;
        w_ptr_d        = '0;
        w_cdb_active_d = 1'b0;
        w_cdb_tag_d    = '0;
        w_cdb_val_d    = '0;
        w_cdb_addr_d   = '0;
      end else begin
        w_slot_valid_d = r_slot_valid & ~w_grant;
        // Tag 0 results are acknowledged but never stored, so they never reach the bus.
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          if (req_valid[i] && req_ready[i] && (req_tag[i*TAG_W +: TAG_W] != '0)) begin
            w_slot_valid_d[i] = 1'b1;
            w_slot_tag_d[i]   = req_tag[i*TAG_W +: TAG_W];
            w_slot_val_d[i]   = req_val[i*DATA_W +: DATA_W];
            w_slot_addr_d[i]  = req_addr[i*DATA_W +: DATA_W];
          end
        end
        if (w_grant_any) begin
          w_ptr_d        = (w_grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
          w_cdb_active_d = 1'b1;
          w_cdb_tag_d    = r_slot_tag[w_grant_idx];
          w_cdb_val_d    = r_slot_val[w_grant_idx];
          w_cdb_addr_d   = r_slot_addr[w_grant_idx];
        end else begin
          w_cdb_active_d = 1'b0;
          w_cdb_tag_d    = '0;
          w_cdb_val_d    = '0;
          w_cdb_addr_d   = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_slot_valid <= '0;
      r_slot_tag   <= '0;
      r_slot_val   <= '0;
      r_slot_addr  <= '0;
      r_ptr        <= '0;
      r_cdb_active <= 1'b0;
      r_cdb_tag    <= '0;
      r_cdb_val    <= '0;
      r_cdb_addr   <= '0;
    end else begin
      r_slot_valid <= w_slot_valid_d;
      r_slot_tag   <= w_slot_tag_d;
      r_slot_val   <= w_slot_val_d;
      r_slot_addr  <= w_slot_addr_d;
      r_ptr        <= w_ptr_d;
      r_cdb_active <= w_cdb_active_d;
      r_cdb_tag    <= w_cdb_tag_d;
      r_cdb_val    <= w_cdb_val_d;
      r_cdb_addr   <= w_cdb_addr_d;
    end
  end

  always_comb begin
    w_pending = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_pending = w_pending + CNT_W'(r_slot_valid[i]);
    end
  end

  assign pending    = w_pending;
  assign cdb_active = r_cdb_active;
  assign cdb_tag    = r_cdb_tag;
  assign cdb_val    = r_cdb_val;
  assign cdb_addr   = r_cdb_addr;

endmodule
